// File: rtl/spi_slave_if.sv
// SPI slave signal bundle: master pins (ss_n/mosi/miso) plus the RAM-side word and byte paths.
// Pure wiring, no latency of its own.
// No backpressure: rx_valid is a one-cycle strobe; tx_valid is a level from the RAM. frame_err exists only with SPI_FRAME_ERR_EN.
interface spi_slave_if #(
    parameter int FRAME_W = 10,
    parameter int DATA_W  = 8
);
    logic               ss_n;
    logic               mosi;
    logic               miso;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;
`ifdef SPI_FRAME_ERR_EN
    logic               frame_err;

    modport slave (
        input  ss_n, mosi, tx_data, tx_valid,
        output miso, rx_data, rx_valid, frame_err
    );
    modport master (
        output ss_n, mosi, tx_data, tx_valid,
        input  miso, rx_data, rx_valid, frame_err
    );
`else
    modport slave (
        input  ss_n, mosi, tx_data, tx_valid,
        output miso, rx_data, rx_valid
    );
    modport master (
        output ss_n, mosi, tx_data, tx_valid,
        input  miso, rx_data, rx_valid
    );
`endif
endinterface

// File: rtl/spi_slave.sv
// SPI slave front end for the SPI RAM: 10-bit MOSI frames in (MSB first), read byte out on MISO (MSB first).
// Latency: rx_valid one cycle after the 10th data edge; tx byte captured >=1 cycle after rx_valid, then 8 MISO bits.
// No backpressure: the master paces everything via ss_n; tx_valid is a level and only its first qualifying edge is used.
// Optional: define SPI_FRAME_ERR_EN to add a frame_err pulse on a premature ss_n rise.
module spi_slave #(
    parameter int FRAME_W = 10,
    parameter int DATA_W  = 8
) (
    input  logic       clk,
    input  logic       rst,
    spi_slave_if.slave bus
);
    localparam int CNT_W = $clog2(FRAME_W + 1);
    localparam int TXC_W = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [TXC_W-1:0] TXC_ONE  = TXC_W'(1);
    localparam logic [TXC_W-1:0] TXC_LAST = TXC_W'(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-2:0] rx_sreg;     // bits received so far; the last bit goes straight into rx_data
    logic [DATA_W-1:0]  tx_sreg;
    logic [TXC_W-1:0]   tx_cnt;      // 0..DATA_W bits driven, DATA_W+1 = byte finished
    logic               tx_loaded;   // one capture per frame
    logic               rd_addr_seen;
    logic               miso_r;
    logic [FRAME_W-1:0] rx_data_r;
    logic               rx_valid_r;

    logic abort, clear_all, start_frame, receiving, last_bit;
    logic capture, shift_out, tx_finish, set_seen, clr_seen;
`ifdef SPI_FRAME_ERR_EN
    logic frame_err_r;
    logic err_cond;
`endif

    // State register; rst wins over everything.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: command decode in CHK_CMD, any ss_n high leaves a frame.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!bus.ss_n) state_nxt = CHK_CMD;
            CHK_CMD: begin
                if (bus.ss_n)          state_nxt = IDLE;
                else if (!bus.mosi)    state_nxt = WRITE;
                else if (rd_addr_seen) state_nxt = READ_DATA;
                else                   state_nxt = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: if (bus.ss_n) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control decode for the datapath registers.
    always_comb begin
        abort       = (state != IDLE) && bus.ss_n;
        clear_all   = abort || (state == IDLE);
        start_frame = (state == CHK_CMD) && !abort;
        receiving   = ((state == WRITE) || (state == READ_ADD) || (state == READ_DATA))
                      && (bit_cnt != CNT_FULL) && !abort;
        last_bit    = receiving && (bit_cnt == CNT_LAST);
        capture     = (state == READ_DATA) && (bit_cnt == CNT_FULL) && !tx_loaded
                      && bus.tx_valid && !abort;
        shift_out   = (state == READ_DATA) && tx_loaded && (tx_cnt < TXC_LAST) && !abort;
        tx_finish   = (state == READ_DATA) && tx_loaded && (tx_cnt == TXC_LAST) && !abort;
        set_seen    = last_bit && (state == READ_ADD);
        // A read-data frame consumes the address once its strobe has gone out, even if cut short.
        clr_seen    = tx_finish || (abort && (state == READ_DATA) && (bit_cnt == CNT_FULL));
`ifdef SPI_FRAME_ERR_EN
        err_cond    = abort && ((bit_cnt != CNT_FULL) ||
                      ((state == READ_DATA) && !(tx_loaded && (tx_cnt >= TXC_LAST))));
`endif
    end

    // Datapath: frame deserialiser, read-byte serialiser and read-address tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt      <= '0;
            rx_sreg      <= '0;
            tx_sreg      <= '0;
            tx_cnt       <= '0;
            tx_loaded    <= 1'b0;
            rd_addr_seen <= 1'b0;
            miso_r       <= 1'b0;
            rx_data_r    <= '0;
            rx_valid_r   <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err_r  <= 1'b0;
`endif
        end else begin
            rx_valid_r <= last_bit;
`ifdef SPI_FRAME_ERR_EN
            frame_err_r <= err_cond;
`endif
            if (clear_all) begin
                bit_cnt   <= '0;
                rx_sreg   <= '0;
                tx_sreg   <= '0;
                tx_cnt    <= '0;
                tx_loaded <= 1'b0;
                miso_r    <= 1'b0;
            end
            if (start_frame) begin
                rx_sreg <= {{(FRAME_W-2){1'b0}}, bus.mosi};
                bit_cnt <= CNT_ONE;
            end
            if (receiving) begin
                rx_sreg <= {rx_sreg[FRAME_W-3:0], bus.mosi};
                bit_cnt <= bit_cnt + CNT_ONE;
            end
            if (last_bit) rx_data_r <= {rx_sreg, bus.mosi};
            if (set_seen) rd_addr_seen <= 1'b1;
            if (clr_seen) rd_addr_seen <= 1'b0;
            if (capture) begin
                tx_sreg   <= bus.tx_data;
                tx_loaded <= 1'b1;
                tx_cnt    <= '0;
            end
            if (shift_out) begin
                miso_r  <= tx_sreg[DATA_W-1];
                tx_sreg <= {tx_sreg[DATA_W-2:0], 1'b0};
                tx_cnt  <= tx_cnt + TXC_ONE;
            end
            if (tx_finish) begin
                miso_r <= 1'b0;
                tx_cnt <= tx_cnt + TXC_ONE;
            end
        end
    end

    assign bus.miso     = miso_r;
    assign bus.rx_data  = rx_data_r;
    assign bus.rx_valid = rx_valid_r;
`ifdef SPI_FRAME_ERR_EN
    assign bus.frame_err = frame_err_r;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed frame table plus random frames against a frame-level model.
// Inputs change 1 time unit after each rising clk edge; outputs are sampled at the same point.
// Model tracks only frame-level facts: command, frame length, capture edge, read-address flag.
module tb_spi_slave;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_slave_if #(.FRAME_W(10), .DATA_W(8)) bus ();
    spi_slave #(.FRAME_W(10), .DATA_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    bit seen     = 1'b0;   // model of "read address already sent"

    typedef struct {
        logic [9:0] frame;
        int         len;       // edges with ss_n low (1 = select edge only)
        int         tv_start;  // first edge at which tx_valid is high (held after)
        logic [7:0] txb;       // byte offered by the RAM at the capture edge
        int         rst_at;    // edge at which rst is pulsed, 0 = none
        logic [9:0] exp_rxd;   // rx_data seen with rx_valid, 0 if no strobe
        logic [7:0] exp_rd;    // MISO bits in the read window after the capture edge
        bit         exp_err;
    } vec_t;

    localparam int NTBL = 16;
    vec_t tbl [NTBL];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_err(input string name, input bit exp);
`ifdef SPI_FRAME_ERR_EN
        check(name, 32'(bus.frame_err), 32'(exp));
`else
        if (exp) n_checks = n_checks + 0;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame: drives ss_n/mosi/tx_*, checks every edge against the model and reports observations.
    task automatic run_frame(input vec_t v, output logic [9:0] obs_rxd,
                             output logic [7:0] obs_rd, output bit obs_err);
        bit full, rdata, err;
        int cap, capw;
        full    = (v.len >= 11);
        rdata   = v.frame[9] && seen;
        capw    = (v.tv_start > 12) ? v.tv_start : 12;
        cap     = (rdata && capw <= v.len) ? capw : 0;
        err     = !full || (rdata && !(cap != 0 && cap + 8 <= v.len));
        obs_rxd = '0;
        obs_rd  = '0;
        obs_err = 1'b0;
        for (int k = 1; k <= v.len + 1; k++) begin
            bit exp_rv, exp_miso;
            bus.ss_n     = (k > v.len);
            bus.mosi     = (k >= 2 && k <= 11) ? v.frame[11-k] : 1'($urandom);
            bus.tx_valid = (k >= v.tv_start);
            bus.tx_data  = (k == cap) ? v.txb : 8'($urandom);
            rst          = (k == v.rst_at);
            tick();
            if (k == v.rst_at) begin
                check("rst_rx_valid", 32'(bus.rx_valid), 32'(0));
                check("rst_miso", 32'(bus.miso), 32'(0));
                check("rst_rx_data", 32'(bus.rx_data), 32'(0));
                check_err("rst_frame_err", 1'b0);
                seen     = 1'b0;
                rst      = 1'b0;
                bus.ss_n = 1'b1;
                tick();
                return;
            end
            exp_rv   = full && (k == 11);
            exp_miso = (cap != 0 && k > cap && k <= cap + 8 && k <= v.len) ? v.txb[cap+8-k] : 1'b0;
            check("rx_valid", 32'(bus.rx_valid), 32'(exp_rv));
            check("miso", 32'(bus.miso), 32'(exp_miso));
            if (exp_rv) check("rx_data", 32'(bus.rx_data), 32'(v.frame));
            check_err("frame_err", (k == v.len + 1) && err);
            if (bus.rx_valid) obs_rxd = bus.rx_data;
            if (k > capw && k <= capw + 8) obs_rd[capw+8-k] = bus.miso;
`ifdef SPI_FRAME_ERR_EN
            if (bus.frame_err) obs_err = 1'b1;
`endif
        end
        if (full && v.frame[9]) seen = !rdata;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [9:0] orx;
        logic [7:0] ord;
        bit         oerr;
        vec_t       r;

        //          frame   len tv   txb    rst exp_rxd exp_rd err
        tbl[0]  = '{10'h08B, 11, 99, 8'h00, 0, 10'h08B, 8'h00, 1'b0}; // write
        tbl[1]  = '{10'h1B6, 11, 99, 8'h00, 0, 10'h1B6, 8'h00, 1'b0}; // write (cmd 01)
        tbl[2]  = '{10'h20F, 11, 99, 8'h00, 0, 10'h20F, 8'h00, 1'b0}; // read address
        tbl[3]  = '{10'h30F, 22, 13, 8'hA5, 0, 10'h30F, 8'hA5, 1'b0}; // read data, RAM one cycle late
        tbl[4]  = '{10'h000,  6, 99, 8'h00, 0, 10'h000, 8'h00, 1'b1}; // aborted after 5 bits
        tbl[5]  = '{10'h001, 11, 99, 8'h00, 0, 10'h001, 8'h00, 1'b0}; // recovers
        tbl[6]  = '{10'h255, 11, 99, 8'h00, 0, 10'h255, 8'h00, 1'b0}; // read address
        tbl[7]  = '{10'h3AA, 20,  1, 8'hFF, 16, 10'h3AA, 8'hE0, 1'b0}; // rst after 3 MISO bits
        tbl[8]  = '{10'h2AA, 20,  1, 8'hFF, 0, 10'h2AA, 8'h00, 1'b0}; // must be read address
        tbl[9]  = '{10'h3C1, 20,  1, 8'h3C, 0, 10'h3C1, 8'h3C, 1'b0}; // tx_valid held high
        tbl[10] = '{10'h200, 11,  1, 8'h00, 0, 10'h200, 8'h00, 1'b0};
        tbl[11] = '{10'h3FE, 20,  1, 8'hC3, 0, 10'h3FE, 8'hC3, 1'b0};
        tbl[12] = '{10'h211, 11, 99, 8'h00, 0, 10'h211, 8'h00, 1'b0};
        tbl[13] = '{10'h301, 15,  1, 8'hF0, 0, 10'h301, 8'hE0, 1'b1}; // read data cut mid-shift
        tbl[14] = '{10'h280, 20,  1, 8'hFF, 0, 10'h280, 8'h00, 1'b0}; // address flag was cleared
        tbl[15] = '{10'h3FF, 10, 99, 8'h00, 0, 10'h000, 8'h00, 1'b1}; // one bit short

        // Reset state, including reset held while selected.
        rst = 1'b1; bus.ss_n = 1'b1; bus.mosi = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = '0;
        tick(); tick();
        check("reset_miso", 32'(bus.miso), 32'(0));
        check("reset_rx_valid", 32'(bus.rx_valid), 32'(0));
        check("reset_rx_data", 32'(bus.rx_data), 32'(0));
        check_err("reset_frame_err", 1'b0);
        bus.ss_n = 1'b0; bus.mosi = 1'b1;
        tick(); tick(); tick();
        check("reset_sel_rx_valid", 32'(bus.rx_valid), 32'(0));
        check("reset_sel_miso", 32'(bus.miso), 32'(0));
        rst = 1'b0; bus.ss_n = 1'b1;
        tick();

        for (int i = 0; i < NTBL; i++) begin
            run_frame(tbl[i], orx, ord, oerr);
            check($sformatf("tbl%0d_rx_data", i), 32'(orx), 32'(tbl[i].exp_rxd));
            check($sformatf("tbl%0d_read_byte", i), 32'(ord), 32'(tbl[i].exp_rd));
`ifdef SPI_FRAME_ERR_EN
            check($sformatf("tbl%0d_frame_err", i), 32'(oerr), 32'(tbl[i].exp_err));
`endif
        end

        // Random frames: lengths, tx_valid timing, data and occasional reset.
        for (int i = 0; i < 80; i++) begin
            r.frame    = 10'($urandom);
            r.len      = $urandom_range(1, 24);
            r.tv_start = $urandom_range(1, 24);
            r.txb      = 8'($urandom);
            r.rst_at   = ($urandom_range(0, 9) == 0) ? $urandom_range(1, r.len) : 0;
            r.exp_rxd  = '0;
            r.exp_rd   = '0;
            r.exp_err  = 1'b0;
            run_frame(r, orx, ord, oerr);
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                bus.ss_n = 1'b1;
                tick();
                check("gap_miso", 32'(bus.miso), 32'(0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
